// File: rtl/regfile_pkg.sv
// Shared constants and port-select encoding for the register file writeback path.
package regfile_pkg;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        PORT_ALU  = 1'b0,
        PORT_LOAD = 1'b1
    } port_sel_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requesters, issue/decode scoreboard taps and register-file write outputs.
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic              r0_valid;
    logic [ADDR_W-1:0] r0_dest;
    logic [DATA_W-1:0] r0_data;
    logic              r0_ready;
    logic              r1_valid;
    logic [ADDR_W-1:0] r1_dest;
    logic [DATA_W-1:0] r1_data;
    logic              r1_ready;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_dest;
    logic [ADDR_W-1:0] chk_src1;
    logic [ADDR_W-1:0] chk_src2;
    logic              hazard;
    logic              issue_err;
    logic [NUM_REGS-1:0] pending;

    logic              RegFileWrite;
    logic [ADDR_W-1:0] Destin;
    logic [DATA_W-1:0] Datain;

    modport master (
        output r0_valid, r0_dest, r0_data, r1_valid, r1_dest, r1_data,
        output issue_valid, issue_dest, chk_src1, chk_src2,
        input  r0_ready, r1_ready, hazard, issue_err, pending,
        input  RegFileWrite, Destin, Datain
    );

    modport slave (
        input  r0_valid, r0_dest, r0_data, r1_valid, r1_dest, r1_data,
        input  issue_valid, issue_dest, chk_src1, chk_src2,
        output r0_ready, r1_ready, hazard, issue_err, pending,
        output RegFileWrite, Destin, Datain
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; grants are combinational, zero latency.
// Under contention the port not granted last wins; both grants held low during reset.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      Reset,
    input  logic      req0,
    input  logic      req1,
    output logic      gnt0,
    output logic      gnt1,
    output port_sel_t sel
);
    port_sel_t last;

    always_ff @(posedge clk) begin
        if (Reset) begin
            last <= PORT_LOAD;
        end else if (gnt0 || gnt1) begin
            last <= gnt1 ? PORT_LOAD : PORT_ALU;
        end
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!Reset) begin
            if (req0 && req1) begin
                gnt0 = (last == PORT_LOAD);
                gnt1 = (last == PORT_ALU);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign sel = gnt1 ? PORT_LOAD : PORT_ALU;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/load writebacks onto the register-file write port and tracks pending destinations.
// Write appears one cycle after transfer (register loads two edges after it); requesters stall on ready.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic               clk,
    input  logic               Reset,
    regfile_wb_arbiter_if.slave bus
);
    logic                gnt0;
    logic                gnt1;
    port_sel_t           sel;
    logic                xfer;
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic                wr_q;
    logic [ADDR_W-1:0]   dest_q;
    logic [DATA_W-1:0]   data_q;
    logic                err_q;
    logic                err_d;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .Reset (Reset),
        .req0  (bus.r0_valid),
        .req1  (bus.r1_valid),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .sel   (sel)
    );

    assign xfer = gnt0 | gnt1;

    // Clear before set so a same-cycle issue (the younger instruction) keeps the bit.
    always_comb begin
        pending_d = pending_q;
        if (wr_q) begin
            pending_d[dest_q] = 1'b0;
        end
        if (bus.issue_valid) begin
            pending_d[bus.issue_dest] = 1'b1;
        end
    end

    assign err_d = bus.issue_valid && pending_q[bus.issue_dest]
                   && !(wr_q && (dest_q == bus.issue_dest));

    always_ff @(posedge clk) begin
        if (Reset) begin
            pending_q <= '0;
            wr_q      <= 1'b0;
            dest_q    <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            wr_q      <= xfer;
            err_q     <= err_d;
            if (xfer) begin
                dest_q <= (sel == PORT_LOAD) ? bus.r1_dest : bus.r0_dest;
                data_q <= (sel == PORT_LOAD) ? bus.r1_data : bus.r0_data;
            end
        end
    end

    assign bus.r0_ready     = gnt0;
    assign bus.r1_ready     = gnt1;
    assign bus.hazard       = pending_q[bus.chk_src1] | pending_q[bus.chk_src2];
    assign bus.issue_err    = err_q;
    assign bus.pending      = pending_q;
    assign bus.RegFileWrite = wr_q;
    assign bus.Destin       = dest_q;
    assign bus.Datain       = data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed table, scoreboard/reset sequences, then random traffic vs a model.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if ifc();

    regfile_wb_arbiter dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (ifc.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state, held as plain values rather than hardware registers.
    bit m_pend [NUM_REGS];
    int m_last;
    bit m_wr;
    int m_dest;
    int m_data;
    bit m_err;
    bit m_g0;
    bit m_g1;

    typedef struct {
        bit v0; int d0; int x0;
        bit v1; int d1; int x1;
        bit rd0; bit rd1; bit wr; int dest; int data;
    } vec_t;

    vec_t tbl [8];

    function automatic vec_t mk(bit v0, int d0, int x0, bit v1, int d1, int x1,
                                bit rd0, bit rd1, bit wr, int dest, int data);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.x0 = x0;
        v.v1 = v1; v.d1 = d1; v.x1 = x1;
        v.rd0 = rd0; v.rd1 = rd1; v.wr = wr; v.dest = dest; v.data = data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NUM_REGS-1:0] model_pending();
        logic [NUM_REGS-1:0] p;
        for (int i = 0; i < NUM_REGS; i++) p[i] = m_pend[i];
        return p;
    endfunction

    task automatic idle_inputs();
        ifc.r0_valid = 1'b0; ifc.r0_dest = '0; ifc.r0_data = '0;
        ifc.r1_valid = 1'b0; ifc.r1_dest = '0; ifc.r1_data = '0;
        ifc.issue_valid = 1'b0; ifc.issue_dest = '0;
        ifc.chk_src1 = '0; ifc.chk_src2 = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        int win;
        int id;
        #1;
        win = -1;
        if (!Reset) begin
            if (ifc.r0_valid && ifc.r1_valid) win = (m_last == 1) ? 0 : 1;
            else if (ifc.r0_valid) win = 0;
            else if (ifc.r1_valid) win = 1;
        end
        m_g0 = (win == 0);
        m_g1 = (win == 1);
        chk("r0_ready", ifc.r0_ready, m_g0);
        chk("r1_ready", ifc.r1_ready, m_g1);
        chk("hazard", ifc.hazard, m_pend[ifc.chk_src1] | m_pend[ifc.chk_src2]);

        if (Reset) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_last = 1; m_wr = 0; m_dest = 0; m_data = 0; m_err = 0;
        end else begin
            id = int'(ifc.issue_dest);
            m_err = ifc.issue_valid && m_pend[id] && !(m_wr && m_dest == id);
            if (m_wr) m_pend[m_dest] = 1'b0;
            if (ifc.issue_valid) m_pend[id] = 1'b1;
            m_wr = (win >= 0);
            if (win == 0) begin m_dest = int'(ifc.r0_dest); m_data = int'(ifc.r0_data); end
            if (win == 1) begin m_dest = int'(ifc.r1_dest); m_data = int'(ifc.r1_data); end
            if (win >= 0) m_last = win;
        end

        @(posedge clk);
        #1;
        chk("RegFileWrite", ifc.RegFileWrite, m_wr);
        chk("Destin", ifc.Destin, m_dest);
        chk("Datain", ifc.Datain, m_data);
        chk("pending", ifc.pending, model_pending());
        chk("issue_err", ifc.issue_err, m_err);
    endtask

    initial begin
        bit h0;
        bit h1;

        tbl[0] = mk(1, 1, 'h11, 1, 2, 'h22, 1, 0, 1, 1, 'h11);
        tbl[1] = mk(1, 4, 'h44, 1, 2, 'h22, 0, 1, 1, 2, 'h22);
        tbl[2] = mk(1, 4, 'h44, 1, 6, 'h66, 1, 0, 1, 4, 'h44);
        tbl[3] = mk(1, 8, 'h88, 1, 6, 'h66, 0, 1, 1, 6, 'h66);
        tbl[4] = mk(1, 3, 'h5A, 0, 0, 0,    1, 0, 1, 3, 'h5A);
        tbl[5] = mk(0, 0, 0,    0, 0, 0,    0, 0, 0, 3, 'h5A);
        tbl[6] = mk(0, 0, 0,    1, 9, 'h99, 0, 1, 1, 9, 'h99);
        tbl[7] = mk(0, 0, 0,    0, 0, 0,    0, 0, 0, 9, 'h99);

        idle_inputs();
        Reset = 1'b1;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_last = 1; m_wr = 0; m_dest = 0; m_data = 0; m_err = 0;
        @(posedge clk);
        #1;
        step();
        chk("reset_wr", ifc.RegFileWrite, 0);
        chk("reset_pending", ifc.pending, 0);
        Reset = 1'b0;

        // Contention then single requests.
        for (int i = 0; i < 8; i++) begin
            ifc.r0_valid = tbl[i].v0; ifc.r0_dest = tbl[i].d0[ADDR_W-1:0]; ifc.r0_data = tbl[i].x0[DATA_W-1:0];
            ifc.r1_valid = tbl[i].v1; ifc.r1_dest = tbl[i].d1[ADDR_W-1:0]; ifc.r1_data = tbl[i].x1[DATA_W-1:0];
            #1;
            chk($sformatf("tbl%0d_rdy0", i), ifc.r0_ready, tbl[i].rd0);
            chk($sformatf("tbl%0d_rdy1", i), ifc.r1_ready, tbl[i].rd1);
            step();
            chk($sformatf("tbl%0d_wr", i), ifc.RegFileWrite, tbl[i].wr);
            chk($sformatf("tbl%0d_dest", i), ifc.Destin, tbl[i].dest);
            chk($sformatf("tbl%0d_data", i), ifc.Datain, tbl[i].data);
        end
        idle_inputs();

        // Hazard lifetime of reg 7 across issue, transfer and write.
        ifc.issue_valid = 1'b1; ifc.issue_dest = 4'd7;
        step();
        ifc.issue_valid = 1'b0; ifc.chk_src1 = 4'd7;
        #1;
        chk("hz7_after_issue", ifc.hazard, 1);
        step();
        ifc.r0_valid = 1'b1; ifc.r0_dest = 4'd7; ifc.r0_data = 8'h31;
        step();
        ifc.r0_valid = 1'b0;
        #1;
        chk("hz7_write_cycle", ifc.hazard, 1);
        chk("wr7_write_cycle", ifc.RegFileWrite, 1);
        step();
        chk("hz7_cleared", ifc.hazard, 0);
        ifc.chk_src1 = '0;

        // Same-cycle set and clear of reg 5.
        ifc.issue_valid = 1'b1; ifc.issue_dest = 4'd5;
        step();
        ifc.issue_valid = 1'b0;
        ifc.r1_valid = 1'b1; ifc.r1_dest = 4'd5; ifc.r1_data = 8'hC3;
        step();
        ifc.r1_valid = 1'b0;
        ifc.issue_valid = 1'b1; ifc.issue_dest = 4'd5;
        step();
        chk("setclr_pend5", ifc.pending[5], 1);
        chk("setclr_err", ifc.issue_err, 0);

        // Double issue to reg 2.
        ifc.issue_dest = 4'd2;
        step();
        step();
        chk("dbl_err", ifc.issue_err, 1);
        chk("dbl_pend2", ifc.pending[2], 1);
        ifc.issue_valid = 1'b0;
        step();
        chk("dbl_err_pulse", ifc.issue_err, 0);

        // Reset in the cycle of a would-be transfer, with the pointer favouring r1.
        ifc.r0_valid = 1'b1; ifc.r0_dest = 4'd4; ifc.r0_data = 8'h77;
        step();
        ifc.r0_dest = 4'd8; ifc.r0_data = 8'h12;
        ifc.r1_valid = 1'b1; ifc.r1_dest = 4'd9; ifc.r1_data = 8'h34;
        Reset = 1'b1;
        #1;
        chk("rst_rdy0", ifc.r0_ready, 0);
        step();
        chk("rst_wr", ifc.RegFileWrite, 0);
        chk("rst_pend", ifc.pending, 0);
        chk("rst_dest", ifc.Destin, 0);
        chk("rst_data", ifc.Datain, 0);
        Reset = 1'b0;
        #1;
        chk("rst_first_conflict_r0", ifc.r0_ready, 1);
        chk("rst_first_conflict_r1", ifc.r1_ready, 0);
        step();
        chk("rst_first_dest", ifc.Destin, 8);
        idle_inputs();

        // Random traffic; requesters hold their request until granted.
        h0 = 1'b0; h1 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            Reset = ($urandom_range(0, 59) == 0);
            if (!h0 && $urandom_range(0, 2) != 0) begin
                h0 = 1'b1;
                ifc.r0_dest = 4'($urandom_range(0, NUM_REGS - 1));
                ifc.r0_data = 8'($urandom_range(0, 255));
            end
            if (!h1 && $urandom_range(0, 2) != 0) begin
                h1 = 1'b1;
                ifc.r1_dest = 4'($urandom_range(0, NUM_REGS - 1));
                ifc.r1_data = 8'($urandom_range(0, 255));
            end
            ifc.r0_valid = h0;
            ifc.r1_valid = h1;
            ifc.issue_valid = ($urandom_range(0, 2) == 0);
            ifc.issue_dest = 4'($urandom_range(0, NUM_REGS - 1));
            ifc.chk_src1 = 4'($urandom_range(0, NUM_REGS - 1));
            ifc.chk_src2 = 4'($urandom_range(0, NUM_REGS - 1));
            step();
            if (m_g0) h0 = 1'b0;
            if (m_g1) h1 = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
